// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, request/grant/response instruction
// memory port, 2-entry {instr, pc} queue towards decode, and redirect squash.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        bxx_flush
);
  timeunit 1ns;
  timeprecision 1ps;

  // Handshakes: a fetch is taken when imem_req && imem_gnt; the queue head is
  // consumed by decode when id_valid && !id_stall. imem_req never depends on imem_gnt.

  logic        r_run;
  logic [31:0] r_pc;
  logic [31:0] r_q_instr [2];
  logic [31:0] r_q_pc    [2];
  logic        r_q_head;
  logic [1:0]  r_q_count;
  logic [31:0] r_tag [2];
  logic        r_tag_rd;
  logic        r_tag_wr;
  logic [1:0]  r_outstanding;
  logic [1:0]  r_drop_cnt;
  logic        r_flush;

  logic        w_grant;
  logic        w_pop;
  logic        w_push;
  logic        w_q_pop;
  logic        w_wr_idx;
  logic [2:0]  w_credit;
  logic [1:0]  w_out_nxt;
  logic [31:0] w_redirect_pc;
  logic        w_unused_ok;

  assign w_unused_ok   = ^redirect_pc[1:0];
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

  assign id_valid = (r_q_count != 2'd0);
  assign id_instr = id_valid ? r_q_instr[r_q_head] : NOP_INSTR;
  assign id_pc    = id_valid ? r_q_pc[r_q_head]    : 32'h0;
  assign bxx_flush = r_flush;

  // A head leaving this cycle frees its slot, which keeps the stream at one
  // instruction per cycle while still bounding entries to two.
  assign w_pop    = id_valid && !id_stall;
  assign w_credit = {1'b0, r_outstanding} + {1'b0, r_q_count} - {2'b00, w_pop};
  assign imem_req  = r_run && (w_credit < 3'd2);
  assign imem_addr = r_pc;

  assign w_grant   = imem_req && imem_gnt;
  assign w_out_nxt = r_outstanding + {1'b0, w_grant} - {1'b0, imem_rvalid};
  assign w_push    = imem_rvalid && (r_drop_cnt == 2'd0) && !redirect_en;
  assign w_q_pop   = w_pop && !redirect_en;
  assign w_wr_idx  = r_q_head ^ r_q_count[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_pc          <= RESET_PC;
      r_outstanding <= 2'd0;
      r_drop_cnt    <= 2'd0;
      r_flush       <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= w_out_nxt;
      r_flush       <= redirect_en;
      if (redirect_en) begin
        r_pc       <= w_redirect_pc;
        // Everything still owed by memory after this edge belongs to the old path.
        r_drop_cnt <= w_out_nxt;
      end else begin
        if (w_grant) begin
          r_pc <= r_pc + 32'd4;
        end
        if (imem_rvalid && (r_drop_cnt != 2'd0)) begin
          r_drop_cnt <= r_drop_cnt - 2'd1;
        end
      end
    end
  end

  // Tag FIFO tracks every granted request, stale or not, so it stays aligned
  // with the memory's in-order responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_rd <= 1'b0;
      r_tag_wr <= 1'b0;
    end else begin
      if (w_grant) begin
        r_tag_wr <= ~r_tag_wr;
      end
      if (imem_rvalid) begin
        r_tag_rd <= ~r_tag_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_tag[r_tag_wr] <= r_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_head  <= 1'b0;
      r_q_count <= 2'd0;
    end else if (redirect_en) begin
      r_q_head  <= 1'b0;
      r_q_count <= 2'd0;
    end else begin
      if (w_q_pop) begin
        r_q_head <= ~r_q_head;
      end
      r_q_count <= r_q_count + {1'b0, w_push} - {1'b0, w_q_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[w_wr_idx] <= imem_rdata;
      r_q_pc[w_wr_idx]    <= r_tag[r_tag_rd];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order random-latency memory model plus a
// program-order reference of the PC stream seen by decode.
module tb_fetch_unit;
  timeunit 1ns;
  timeprecision 1ps;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        bxx_flush;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .id_stall(id_stall), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .bxx_flush(bxx_flush)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int   gnt_pct   = 100;
  int   stall_pct = 0;
  int   lat_min   = 1;
  int   lat_max   = 1;
  logic force_stall = 1'b0;
  logic redir_req   = 1'b0;
  logic [31:0] redir_tgt = 32'h0;

  // memory model: in-order pending requests with their due cycle
  logic [31:0] mem_addr_q[$];
  int          mem_rdy_q[$];
  int          last_rdy = 0;

  // reference model: next program-order PC decode should receive
  logic [31:0] exp_pc;
  logic        exp_flush;
  logic [31:0] acc_q[$];
  logic [31:0] exp_q[$];

  logic        s_req, s_valid, s_flush;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    int lat;
    int rdy;
    @(negedge clk);
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    id_stall    = force_stall || ($urandom_range(99) < stall_pct);
    redirect_en = redir_req;
    redirect_pc = redir_tgt;
    redir_req   = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (mem_addr_q.size() > 0 && mem_rdy_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_rdy_q.pop_front());
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = id_valid;
    s_pc = id_pc; s_flush = bxx_flush;
    if (!rst_n) begin
      check("rst_req", imem_req, 1'b0);
      check("rst_addr", imem_addr, RST_PC);
      check("rst_valid", id_valid, 1'b0);
      check("rst_instr", id_instr, NOP);
      check("rst_pc", id_pc, 32'h0);
      check("rst_flush", bxx_flush, 1'b0);
    end else begin
      check("flush", bxx_flush, exp_flush);
      if (exp_flush) check("valid_on_flush", id_valid, 1'b0);
      check("addr_align", imem_addr[1:0], 2'b00);
      if (!id_valid) begin
        check("idle_instr", id_instr, NOP);
        check("idle_pc", id_pc, 32'h0);
      end
      if (redirect_en) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (id_valid && !id_stall) begin
        check("seq_pc", id_pc, exp_pc);
        check("seq_instr", id_instr, mem_word(exp_pc));
        acc_q.push_back(id_pc);
        exp_pc = exp_pc + 32'd4;
      end
      exp_flush = redirect_en;
      if (imem_req && imem_gnt) begin
        lat = $urandom_range(lat_max, lat_min);
        rdy = (cyc + lat > last_rdy) ? cyc + lat : last_rdy + 1;
        last_rdy = rdy;
        mem_addr_q.push_back(imem_addr);
        mem_rdy_q.push_back(rdy);
      end
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_en = 1'b0; id_stall = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while (acc_q.size() < n && i < budget) begin
      cycle();
      i++;
    end
    if (acc_q.size() < n) check(tag, 32'(acc_q.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n0;
    logic [31:0] stall_pc;
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_en = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
    exp_pc = RST_PC; exp_flush = 1'b0;

    repeat (3) cycle();
    release_reset();

    // steady stream: L=1, always granted, no stall
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("stream_req", s_req, 1'b1);
      check("stream_addr", s_addr, RST_PC + 32'(4 * k));
      if (k >= 2) begin
        check("stream_valid", s_valid, 1'b1);
        check("stream_pc", s_pc, RST_PC + 32'(4 * (k - 2)));
      end else begin
        check("stream_fill_valid", s_valid, 1'b0);
      end
    end

    // stall backpressure
    force_stall = 1'b1;
    cycle();
    stall_pc = s_pc;
    repeat (4) begin
      cycle();
      check("stall_hold_pc", s_pc, stall_pc);
      check("stall_hold_valid", s_valid, 1'b1);
    end
    check("stall_req_low", s_req, 1'b0);
    force_stall = 1'b0;
    cycle();
    check("stall_release_pc", s_pc, stall_pc);
    repeat (6) cycle();

    // redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && mem_addr_q.size() != 2; i++) cycle();
    check("two_in_flight", 32'(mem_addr_q.size()), 32'd2);
    redir_req = 1'b1; redir_tgt = 32'h0000_0203;
    cycle();
    n0 = acc_q.size();
    cycle();
    check("redir_flush", s_flush, 1'b1);
    check("redir_flush_valid", s_valid, 1'b0);
    cycle();
    check("redir_flush_pulse", s_flush, 1'b0);
    run_until(n0 + 1, 40, "redir_timeout");
    if (acc_q.size() > n0) check("redir_target_pc", acc_q[n0], 32'h0000_0200);

    // drain, then redirect coinciding with a response and a new grant
    gnt_pct = 0;
    repeat (8) cycle();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    repeat (6) cycle();
    redir_req = 1'b1; redir_tgt = 32'h0000_0400;
    cycle();
    check("simul_req", s_req, 1'b1);
    cycle();
    cycle();
    check("simul_drop_valid", s_valid, 1'b0);
    cycle();
    check("simul_first_valid", s_valid, 1'b1);
    check("simul_first_pc", s_pc, 32'h0000_0400);

    // wrap with variable latency and random grant/stall
    lat_min = 1; lat_max = 4; gnt_pct = 60; stall_pct = 20;
    redir_req = 1'b1; redir_tgt = 32'hFFFF_FFFC;
    cycle();
    n0 = acc_q.size();
    run_until(n0 + 3, 300, "wrap_timeout");
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    for (int i = 0; i < 3; i++) begin
      if (acc_q.size() > n0 + i) check("wrap_pc", acc_q[n0 + i], exp_q[i]);
    end

    // random traffic with random redirects
    n0 = acc_q.size();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 4) begin
        redir_req = 1'b1;
        redir_tgt = $urandom;
      end
      cycle();
    end
    check("random_progress", 32'(acc_q.size() > n0 + 20), 32'd1);

    // asynchronous reset in the middle of a burst
    lat_min = 2; lat_max = 2; gnt_pct = 100; stall_pct = 0;
    repeat (5) cycle();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_req", imem_req, 1'b0);
    check("arst_addr", imem_addr, RST_PC);
    check("arst_valid", id_valid, 1'b0);
    check("arst_instr", id_instr, NOP);
    check("arst_pc", id_pc, 32'h0);
    check("arst_flush", bxx_flush, 1'b0);
    mem_addr_q.delete();
    mem_rdy_q.delete();
    last_rdy = cyc;
    exp_pc = RST_PC;
    exp_flush = 1'b0;
    repeat (2) cycle();
    release_reset();
    n0 = acc_q.size();
    run_until(n0 + 4, 50, "restart_timeout");
    if (acc_q.size() > n0) check("restart_pc", acc_q[n0], RST_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
